// File: rtl/keypad_defs.sv
// Shared keypad definitions: matrix size, key_code fields, FSM states.
// Used by both the keypad emulator and the scanner side of the chain.
package keypad_defs;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    // key_code = {row index, column index}
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_ROW_W   = 2;
    localparam int KEY_COL_LSB = 0;
    localparam int KEY_COL_W   = 2;

    localparam int HOLD_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_BOUNCE,
        ST_HOLD,
        ST_RELEASE_BOUNCE,
        ST_GAP
    } key_state_t;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for contact bounce.
// Ports: clk, RSTn (async low), step (advance once), bit0 (current LSB).
module bounce_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic RSTn,
    input  logic step,
    output logic bit0
);

    logic [15:0] q;
    logic        fb;

    assign fb   = q[0] ^ q[2] ^ q[3] ^ q[5];
    assign bit0 = q[0];

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            q <= SEED;
        end else if (step) begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 keypad: takes press commands, emulates bounce and hold,
// answers row drive on col. Ports: clk, RSTn, row, col, key_code,
// hold_len, press_valid/press_ready, release_now, busy, contact, done.
module keypad_matrix_emulator
    import keypad_defs::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 500_000,
    parameter int unsigned BOUNCE_STEP   = 25_000,
    parameter int unsigned DEFAULT_HOLD  = 5_000_000,
    parameter int unsigned GAP_CYCLES    = 2_500_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic [KEY_ROWS-1:0] row,
    output logic [KEY_COLS-1:0] col,
    input  logic [3:0]          key_code,
    input  logic [HOLD_W-1:0]   hold_len,
    input  logic                press_valid,
    output logic                press_ready,
    input  logic                release_now,
    output logic                busy,
    output logic                contact,
    output logic                done
);

    localparam int unsigned CNT_MAX =
        max3(BOUNCE_CYCLES, GAP_CYCLES, 32'd1 << HOLD_W);
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int STEP_W = $clog2(BOUNCE_STEP + 1);

    key_state_t state;
    key_state_t state_next;

    logic [CNT_W-1:0]  cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [3:0]        code_q;
    logic [HOLD_W-1:0] hold_q;
    logic              contact_q;

    logic bounce_end;
    logic hold_end;
    logic gap_end;
    logic in_bounce;
    logic enter_bounce;
    logic bounce_stay;
    logic lfsr_step;
    logic lfsr_bit;

    logic [KEY_ROW_W-1:0] code_row;
    logic [KEY_COL_W-1:0] code_col;

    assign bounce_end = cnt == CNT_W'(BOUNCE_CYCLES - 1);
    assign gap_end    = cnt == CNT_W'(GAP_CYCLES - 1);
    assign hold_end   = cnt == CNT_W'(hold_q) - CNT_W'(1);

    assign in_bounce = (state == ST_PRESS_BOUNCE)
                    || (state == ST_RELEASE_BOUNCE);

    // A bounce window takes its first contact sample on entry.
    assign enter_bounce =
        ((state == ST_IDLE) && (state_next == ST_PRESS_BOUNCE))
     || ((state == ST_HOLD) && (state_next == ST_RELEASE_BOUNCE));

    assign bounce_stay = in_bounce && (state_next == state);

    assign lfsr_step = enter_bounce
        || (bounce_stay && (step_cnt == STEP_W'(BOUNCE_STEP - 1)));

    assign code_row = code_q[KEY_ROW_LSB +: KEY_ROW_W];
    assign code_col = code_q[KEY_COL_LSB +: KEY_COL_W];

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .RSTn (RSTn),
        .step (lfsr_step),
        .bit0 (lfsr_bit)
    );

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (press_valid) state_next = ST_PRESS_BOUNCE;
            end
            ST_PRESS_BOUNCE: begin
                if (bounce_end) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_end || release_now) begin
                    state_next = ST_RELEASE_BOUNCE;
                end
            end
            ST_RELEASE_BOUNCE: begin
                if (bounce_end) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_end) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        press_ready = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        done        = (state == ST_GAP) && gap_end;
        contact     = contact_q;
        col         = '1;
        if (contact_q && !row[code_row]) begin
            col[code_col] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            cnt       <= '0;
            step_cnt  <= '0;
            code_q    <= '0;
            hold_q    <= '0;
            contact_q <= 1'b0;
        end else begin
            // Timer restarts on every state change and idles at 0.
            if ((state_next != state) || (state == ST_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (lfsr_step) begin
                step_cnt <= '0;
            end else if (bounce_stay) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end else begin
                step_cnt <= '0;
            end

            if (lfsr_step) begin
                contact_q <= lfsr_bit;
            end else if (state_next == ST_HOLD) begin
                contact_q <= 1'b1;
            end else if (!bounce_stay) begin
                contact_q <= 1'b0;
            end

            if ((state == ST_IDLE) && press_valid) begin
                code_q <= key_code;
                if (hold_len == '0) begin
                    hold_q <= HOLD_W'(DEFAULT_HOLD);
                end else begin
                    hold_q <= hold_len;
                end
            end
        end
    end

endmodule
